pwm_capture: RTL and testbench

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_pkg.sv | 12 +
 rtl/pwm_sync_edge.sv | 29 ++
 rtl/pwm_capture.sv | 125 ++++++++++++
 tb/tb_pwm_capture.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM measurement blocks.
package pwm_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MEAS_HIGH = 2'd1,
        MEAS_LOW  = 2'd2
    } state_t;

endpackage

// File: rtl/pwm_sync_edge.sv
// Synchronizes the asynchronous PWM input and flags rising/falling edges.
module pwm_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   hist_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= '0;
            hist_p1 <= 1'b0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], pwm_in};
            hist_p1 <= sync_p0[SYNC_STAGES-1];
        end
    end

    // Synchronized level against its one-cycle-old copy.
    assign rise = sync_p0[SYNC_STAGES-1] & ~hist_p1;
    assign fall = ~sync_p0[SYNC_STAGES-1] & hist_p1;

endmodule

// File: rtl/pwm_capture.sv
// Measures PWM period and high time in prescaler ticks, rise to rise.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             tick,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic t);
        return (t && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
    endfunction

    logic             rise;
    logic             fall;
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] hi_lat, hi_lat_n;
    logic [CNT_W-1:0] period_n, high_time_n;
    logic             valid_n, timeout_n;
    logic             sat;
    logic [CNT_W-1:0] cnt_load;

    pwm_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk   (clk),
        .rst   (rst),
        .pwm_in(pwm_in),
        .rise  (rise),
        .fall  (fall)
    );

    // A tick landing in the edge cycle belongs to the new measurement.
    assign cnt_load = CNT_W'(tick);
    assign sat      = (cnt == CNT_MAX) && tick;

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        hi_lat_n    = hi_lat;
        period_n    = period;
        high_time_n = high_time;
        valid_n     = 1'b0;
        timeout_n   = 1'b0;
        if (!en) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        state_n = MEAS_HIGH;
                        cnt_n   = cnt_load;
                    end
                end
                MEAS_HIGH: begin
                    if (sat) begin
                        state_n   = IDLE;
                        cnt_n     = '0;
                        timeout_n = 1'b1;
                    end else begin
                        cnt_n = sat_inc(cnt, tick);
                        if (fall) begin
                            hi_lat_n = cnt;
                            state_n  = MEAS_LOW;
                        end
                    end
                end
                MEAS_LOW: begin
                    // Saturation abandons the measurement even if an edge arrives now.
                    if (sat) begin
                        state_n   = IDLE;
                        cnt_n     = '0;
                        timeout_n = 1'b1;
                    end else if (rise) begin
                        period_n    = cnt;
                        high_time_n = hi_lat;
                        valid_n     = 1'b1;
                        cnt_n       = cnt_load;
                        state_n     = MEAS_HIGH;
                    end else begin
                        cnt_n = sat_inc(cnt, tick);
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            hi_lat    <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            hi_lat    <= hi_lat_n;
            period    <= period_n;
            high_time <= high_time_n;
            valid     <= valid_n;
            timeout   <= timeout_n;
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture against a tick-window reference model.
module tb_pwm_capture;

    localparam int S    = 2;
    localparam int NMAX = 8000;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        tick;
    logic        pwm_in;
    logic [15:0] period;
    logic [15:0] high_time;
    logic        valid;
    logic        timeout;

    pwm_capture #(
        .CNT_W      (16),
        .SYNC_STAGES(S)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .tick     (tick),
        .pwm_in   (pwm_in),
        .period   (period),
        .high_time(high_time),
        .valid    (valid),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Stimulus tables, one entry per clock edge.
    bit pwm_a [NMAX];
    bit tick_a[NMAX];
    bit en_a  [NMAX];
    int w = 0;

    // Reference model: a measurement is the tick count over a window of edges.
    int          m_rise  = 0;
    int          m_fall  = 0;
    bit          m_armed = 1'b0;
    bit          m_fell  = 1'b0;
    bit          e_valid = 1'b0;
    logic [15:0] e_period = '0;
    logic [15:0] e_high   = '0;
    int          n_valid  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic int sum_ticks(input int a, input int b);
        int s = 0;
        for (int i = a; i < b; i++) s += int'(tick_a[i]);
        return s;
    endfunction

    task automatic add_pulse(input int hi, input int lo, input int tmode);
        int w0 = w;
        for (int i = 0; i < hi + lo; i++) begin
            if (w >= NMAX) begin
                $display("FAIL stimulus_table overflow at %0d", w);
                $fatal(1);
            end
            pwm_a[w] = (i < hi);
            if (tmode == 0)      tick_a[w] = 1'b1;
            else if (tmode == 1) tick_a[w] = 1'($urandom_range(0, 1));
            else                 tick_a[w] = (((w - w0 + 4 - S) % 4) == 0);
            en_a[w] = 1'b1;
            w++;
        end
    endtask

    task automatic run(input int from, input int to);
        bit cur, prv;
        for (int p = from; p < to; p++) begin
            pwm_in = pwm_a[p];
            tick   = tick_a[p];
            en     = en_a[p];
            @(posedge clk);
            cur = (p >= S)     ? pwm_a[p-S]   : 1'b0;
            prv = (p >= S + 1) ? pwm_a[p-S-1] : 1'b0;
            e_valid = 1'b0;
            if (!en_a[p]) begin
                m_armed = 1'b0;
            end else if (cur && !prv) begin
                if (m_armed && m_fell) begin
                    e_valid  = 1'b1;
                    e_period = 16'(sum_ticks(m_rise, p));
                    e_high   = 16'(sum_ticks(m_rise, m_fall));
                end
                m_rise  = p;
                m_armed = 1'b1;
                m_fell  = 1'b0;
            end else if (!cur && prv && m_armed && !m_fell) begin
                m_fell = 1'b1;
                m_fall = p;
            end
            #1;
            if (valid) n_valid++;
            chk("valid",     32'(valid),     32'(e_valid));
            chk("timeout",   32'(timeout),   0);
            chk("period",    32'(period),    32'(e_period));
            chk("high_time", 32'(high_time), 32'(e_high));
        end
    endtask

    initial begin
        int m1, m2, m3a, m3, m4, s2, mr, m6, e0, v0, c, vc;
        bit seen;

        rst = 1'b1; en = 1'b0; tick = 1'b0; pwm_in = 1'b0;

        add_pulse(0, 10, 0);
        repeat (4) add_pulse(10, 30, 0);
        m1 = w;
        repeat (3) add_pulse(40, 120, 2);
        m2 = w;
        repeat (2) add_pulse(10, 30, 0);
        e0 = w;
        add_pulse(20, 30, 0);
        for (int i = e0 + 5; i < e0 + 15; i++) en_a[i] = 1'b0;
        m3a = e0 + 15;
        repeat (3) add_pulse(10, 30, 0);
        m3 = w;
        repeat (150) begin
            int h, l, r0, st, ln;
            h  = int'($urandom_range(1, 20));
            l  = int'($urandom_range(1, 25));
            r0 = w;
            add_pulse(h, l, 1);
            if ($urandom_range(0, 9) == 0) begin
                st = r0 + int'($urandom_range(0, h + l - 1));
                ln = int'($urandom_range(1, 8));
                for (int i = st; i < st + ln && i < w; i++) en_a[i] = 1'b0;
            end
        end
        m4 = w;
        add_pulse(10, 30, 0);
        s2 = w;
        add_pulse(10, 30, 0);
        add_pulse(0, 60, 0);
        mr = s2 + 35;
        repeat (4) add_pulse(1, 5, 0);
        add_pulse(0, 10, 0);
        m6 = w;

        #12;
        chk("rst_period",    32'(period),    0);
        chk("rst_high_time", 32'(high_time), 0);
        chk("rst_valid",     32'(valid),     0);
        chk("rst_timeout",   32'(timeout),   0);
        @(negedge clk);
        rst = 1'b0;

        run(0, m1);
        chk("const_tick_period", 32'(period),    40);
        chk("const_tick_high",   32'(high_time), 10);
        run(m1, m2);
        chk("div4_tick_period", 32'(period),    40);
        chk("div4_tick_high",   32'(high_time), 10);
        run(m2, m3a);
        chk("en_low_period_hold", 32'(period), 40);
        v0 = n_valid;
        run(m3a, m3);
        chk("en_restore_valids", 32'(n_valid - v0), 2);
        run(m3, m4);
        run(m4, mr);
        chk("pre_rst_period", 32'(period), 40);

        #1 rst = 1'b1;
        #1;
        chk("async_rst_period",    32'(period),    0);
        chk("async_rst_high_time", 32'(high_time), 0);
        chk("async_rst_valid",     32'(valid),     0);
        chk("async_rst_timeout",   32'(timeout),   0);
        m_armed = 1'b0; m_fell = 1'b0; e_period = '0; e_high = '0;
        #1 rst = 1'b0;
        run(mr, m6);
        chk("short_pulse_high",   32'(high_time), 1);
        chk("short_pulse_period", 32'(period),    6);

        // Return to IDLE first so the single rise starts a fresh measurement.
        en = 1'b0; tick = 1'b1; pwm_in = 1'b0;
        repeat (4) @(posedge clk);
        #1 en = 1'b1;
        pwm_in = 1'b1;
        seen = 1'b0; vc = 0; c = 0;
        for (int k = 1; k <= 70000; k++) begin
            @(posedge clk);
            #1;
            if (valid) vc++;
            if (timeout) begin
                seen = 1'b1;
                c = k;
                break;
            end
        end
        chk("timeout_seen",      32'(seen), 1);
        chk("timeout_latency",   32'(c), 32'(S + 65536));
        chk("timeout_no_valid",  32'(vc), 0);
        chk("timeout_period",    32'(period),    6);
        chk("timeout_high_time", 32'(high_time), 1);
        repeat (20) begin
            @(posedge clk);
            #1;
            chk("timeout_single", 32'(timeout), 0);
            chk("idle_no_valid",  32'(valid),   0);
        end
        pwm_in = 1'b0;
        repeat (4) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
